bias_post_proc: RTL and testbench
=================================

Name: bias_post_proc

Overview:
- Post-processing stage directly downstream of the bias buffer; consumes its held bias output and the PE-array accumulated partial sums.
- Per output pixel: adds bias, applies rounding right-shift requantization, optional ReLU, and saturates to the activation width.
- Owns the bias buffer's bias_read control, so each channel's bias is held for exactly pixels_per_ch pixels and the next bias is loaded at the channel boundary.

Parameters:
acc_width, 20, partial-sum width (signed)
bias_width, 8, bias width (signed); must match the bias buffer's output_width
out_width, 8, output activation width (signed)
pixels_per_ch, 16, pixels per output channel (>=1)
shift_width, 5, width of the requant shift amount

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a layer pass, honoured only in IDLE
num_ch  input  16  channel count, latched at start; 0 treated as 1
shift_amt  input  shift_width  requant right shift, latched at start
bias_in  input  bias_width  signed bias from the bias buffer's output
bias_read  output  1  to bias buffer: 1 = hold bias, 0 = load next
psum_valid  input  1  partial sum valid
psum_ready  output  1  partial sum accepted when valid && ready
psum_in  input  acc_width  signed partial sum
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  out_width  signed requantized result
ch_done  output  1  one-cycle pulse when the last pixel of a channel is accepted
done  output  1  one-cycle pulse when the layer pass completes
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low) puts the block in IDLE with:
  - bias_read=0, psum_ready=0, out_valid=0, out_data=0, ch_done=0, done=0, busy=0.
  - All counters and pipeline registers cleared.
  - An in-flight pass is abandoned; nothing is output after reset releases.
- FSM states: IDLE, RUN, LOAD, DRAIN.
- IDLE:
  - bias_read=0, so the buffer tracks its input.
  - psum_ready=0.
  - On start: latch num_ch and shift_amt, clear pix_cnt and ch_cnt, go to RUN. The buffer captures the channel-0 bias on the same edge.
- RUN:
  - bias_read=1; psum_ready=adv.
  - adv = !out_valid || out_ready (global pipeline advance).
  - Each accepted psum increments pix_cnt.
  - When the accepted psum is pixel pixels_per_ch-1:
    - Set pix_cnt=0 and pulse ch_done.
    - If ch_cnt==num_ch-1, go to DRAIN; otherwise increment ch_cnt and go to LOAD.
- LOAD:
  - Lasts exactly one cycle.
  - bias_read=0 and psum_ready=0; the buffer captures the next bias at the end of the cycle.
  - Goes to RUN.
  - The upstream bias source must present the next-channel bias on the buffer input by this cycle.
- DRAIN:
  - psum_ready=0.
  - Waits until both pipeline stages are empty and the last result has been accepted.
  - Then pulses done and goes to IDLE.
- Pipeline (two stages, both advancing on adv):
  - S1: sum = sign-extended psum_in + sign-extended bias_in, acc_width+1 bits, registered with a valid bit.
  - S2: if shift>0, r = (sum + 2^(shift-1)) >>> shift (arithmetic shift, round-half-up); otherwise r = sum. Then activation and saturation (see Optional Feature). S2 drives out_valid and out_data.
  - Latency: 2 cycles from accept to out_valid when not stalled; throughput 1 per cycle.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- The bias is sampled in S1 at accept time, so LOAD never corrupts in-flight data.
- start is ignored outside IDLE.
- ch_done and done may coincide with out_valid; they are independent.

Optional Feature:
- Macro POST_RELU_EN.
- Defined: negative r maps to 0; positive r saturates to 2^(out_width-1)-1 (127 by default).
- Undefined: signed saturation of r to [-2^(out_width-1), 2^(out_width-1)-1] ([-128,127]); no ReLU.

Test Plan:
- Reset mid-RUN (after 5 of 16 pixels): assert rst_n=0 -> all outputs 0, state IDLE, no further out_valid after release.
- num_ch=2, shift=0, bias 10 then -3, psum=1..16 per channel, out_ready=1 -> out_data 11..26 then -2..13.
  - Each result appears 2 cycles after its accept.
  - bias_read low for exactly one LOAD cycle between channels.
  - ch_done pulses twice; done pulses once.
- shift=2, bias 0, psum 6 -> out 2 (rounded 1.5 up); psum -6 -> out -1 without POST_RELU_EN, 0 with it.
- psum 100000, bias 0, shift 0 -> out 127; psum -100000 -> out -128 without POST_RELU_EN, 0 with it.
- out_ready held low 4 cycles in RUN while psum_valid=1 -> psum_ready drops once both stages are full.
  - out_data holds stable for the 4 cycles.
  - No pixel is lost or duplicated.
  - The full channel still yields exactly 16 outputs.
- num_ch=0, pixels_per_ch=16, single start -> treated as one channel: 16 outputs, one ch_done, one done, no LOAD state.

Source files
------------

// File: rtl/bias_post_proc.sv
// -----------------------------------------------------------------------------
// bias_post_proc
//
// Post-processing stage that sits directly behind the bias buffer. For every
// output pixel it adds the channel bias to the PE-array partial sum, applies a
// rounding (round-half-up) arithmetic right shift, then either ReLU + clamp or
// signed saturation down to the activation width.
//
// The block owns the bias buffer's bias_read control: the buffer tracks its
// input while bias_read is low and holds while it is high. bias_read is low in
// IDLE (so the channel-0 bias is captured on the start edge) and for a single
// LOAD cycle at every channel boundary (next bias captured at its end).
//
// Optional feature (compile-time macro POST_RELU_EN):
//   defined   : negative results map to 0, positive results clamp to 2^(OW-1)-1
//   undefined : signed saturation to [-2^(OW-1), 2^(OW-1)-1]
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          pulse, starts a layer pass (IDLE only)
//   num_ch         channel count, latched at start (0 behaves as 1)
//   shift_amt      requant right shift, latched at start
//   bias_in        signed bias from the bias buffer output
//   bias_read      to bias buffer: 1 = hold, 0 = load next
//   psum_valid/psum_ready/psum_in   partial-sum handshake (accept on both high)
//   out_valid/out_ready/out_data    result handshake, data held while stalled
//   ch_done        one-cycle pulse after the last pixel of a channel is accepted
//   done           one-cycle pulse when the pass has fully drained
//   busy           high in every state except IDLE
// -----------------------------------------------------------------------------
module bias_post_proc #(
  parameter int ACC_WIDTH     = 20,
  parameter int BIAS_WIDTH    = 8,
  parameter int OUT_WIDTH     = 8,
  parameter int PIXELS_PER_CH = 16,
  parameter int SHIFT_WIDTH   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            num_ch,
  input  logic [SHIFT_WIDTH-1:0] shift_amt,
  input  logic [BIAS_WIDTH-1:0]  bias_in,
  output logic                   bias_read,
  input  logic                   psum_valid,
  output logic                   psum_ready,
  input  logic [ACC_WIDTH-1:0]   psum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   ch_done,
  output logic                   done,
  output logic                   busy
);

  // Sum of psum and bias needs one extra bit; the rounding add needs one more.
  localparam int SUM_W = ACC_WIDTH + 1;
  localparam int RND_W = ACC_WIDTH + 2;
  localparam int PIX_W = (PIXELS_PER_CH > 1) ? $clog2(PIXELS_PER_CH) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS_PER_CH - 1);

  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (OUT_WIDTH - 1)) - 1);
`ifndef POST_RELU_EN
  localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(1 << (OUT_WIDTH - 1)));
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_LOAD,
    ST_DRAIN
  } state_e;

  // ---------------------------------------------------------------------------
  // State and pipeline registers
  // ---------------------------------------------------------------------------
  state_e                   state_q;
  logic [PIX_W-1:0]         pix_cnt_q;
  logic [15:0]              ch_cnt_q;
  logic [15:0]              last_ch_q;
  logic [SHIFT_WIDTH-1:0]   shift_q;
  logic                     ch_done_q;
  logic                     done_q;

  logic                     s1_valid_q;
  logic signed [SUM_W-1:0]  s1_sum_q;
  logic                     s2_valid_q;
  logic [OUT_WIDTH-1:0]     out_data_q;

  // ---------------------------------------------------------------------------
  // Handshake and control decode
  // ---------------------------------------------------------------------------
  logic adv;         // whole pipeline may move this cycle
  logic accept;      // a partial sum is taken this cycle
  logic last_pix;
  logic last_ch;
  logic pipe_empty;

  always_comb begin
    adv        = !s2_valid_q || out_ready;
    accept     = (state_q == ST_RUN) && psum_valid && adv;
    last_pix   = (pix_cnt_q == PIX_LAST);
    last_ch    = (ch_cnt_q == last_ch_q);
    pipe_empty = !s1_valid_q && !s2_valid_q;
  end

  // bias_read and busy decode straight from the state register, so they are
  // glitch-free towards the bias buffer. psum_ready must follow out_ready in
  // the same cycle to keep full throughput, hence it stays combinational.
  assign bias_read  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign psum_ready = (state_q == ST_RUN) && adv;
  assign busy       = (state_q != ST_IDLE);
  assign ch_done    = ch_done_q;
  assign done       = done_q;
  assign out_valid  = s2_valid_q;
  assign out_data   = out_data_q;

  // ---------------------------------------------------------------------------
  // Control FSM: channel/pixel bookkeeping and the registered pulses
  // ---------------------------------------------------------------------------
  // NOTE: every register is written with <= so all flops update from the same
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      ch_cnt_q  <= '0;
      last_ch_q <= '0;
      shift_q   <= '0;
      ch_done_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ch_done_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            // A channel count of zero runs a single channel.
            last_ch_q <= (num_ch == 16'd0) ? 16'd0 : num_ch - 16'd1;
            shift_q   <= shift_amt;
            pix_cnt_q <= '0;
            ch_cnt_q  <= '0;
            state_q   <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (accept) begin
            if (last_pix) begin
              pix_cnt_q <= '0;
              ch_done_q <= 1'b1;
              if (last_ch) begin
                state_q <= ST_DRAIN;
              end else begin
                ch_cnt_q <= ch_cnt_q + 16'd1;
                state_q  <= ST_LOAD;
              end
            end else begin
              pix_cnt_q <= pix_cnt_q + PIX_W'(1);
            end
          end
        end

        // bias_read is low for this one cycle; the buffer loads at its end.
        ST_LOAD: state_q <= ST_RUN;

        ST_DRAIN: begin
          if (pipe_empty) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 input: bias is sampled together with the psum at accept time, so
  // a later bias change (LOAD) cannot disturb data already in flight.
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] psum_ext;
  logic signed [SUM_W-1:0] bias_ext;
  logic signed [SUM_W-1:0] s1_sum_d;

  always_comb begin
    psum_ext = SUM_W'($signed(psum_in));
    bias_ext = SUM_W'($signed(bias_in));
    s1_sum_d = psum_ext + bias_ext;
  end

  // ---------------------------------------------------------------------------
  // Stage 2 input: rounding shift, then activation / saturation
  // ---------------------------------------------------------------------------
  logic signed [RND_W-1:0] sum_wide;
  logic signed [RND_W-1:0] rnd;
  logic signed [RND_W-1:0] rnd_sum;
  logic signed [RND_W-1:0] r;
  logic [OUT_WIDTH-1:0]    out_data_d;

  // NOTE: every variable in this block gets a default assignment first, so no
  // path through the branches can leave one unassigned and infer a latch.
  always_comb begin
    sum_wide   = RND_W'(s1_sum_q);
    rnd        = '0;
    rnd_sum    = sum_wide;
    r          = sum_wide;
    out_data_d = '0;

    if (shift_q == '0) begin
      r = sum_wide;
    end else if (int'(shift_q) >= SUM_W) begin
      // Half-LSB offset dominates any representable sum: the result is 0.
      r = '0;
    end else begin
      rnd     = RND_W'(1) << (shift_q - SHIFT_WIDTH'(1));
      rnd_sum = sum_wide + rnd;
      r       = rnd_sum >>> shift_q;
    end

`ifdef POST_RELU_EN
    if (r[RND_W-1]) begin
      out_data_d = '0;
    end else if (r > SAT_MAX) begin
      out_data_d = SAT_MAX[OUT_WIDTH-1:0];
    end else begin
      out_data_d = r[OUT_WIDTH-1:0];
    end
`else
    if (r > SAT_MAX) begin
      out_data_d = SAT_MAX[OUT_WIDTH-1:0];
    end else if (r < SAT_MIN) begin
      out_data_d = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      out_data_d = r[OUT_WIDTH-1:0];
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Two-stage pipeline, both stages gated by the global advance
  // ---------------------------------------------------------------------------
  // NOTE: the data registers are reset along with the valid bits so that
  // out_data reads 0 after reset and an abandoned pass leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
    end else if (adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q <= s1_sum_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
      end
    end
  end

endmodule

// File: tb/tb_bias_post_proc.sv
// -----------------------------------------------------------------------------
// Testbench for bias_post_proc (default parameters, 16 pixels per channel).
// A small bias-buffer model sits between the bench's bias source and the DUT,
// so wrong bias_read timing shows up as wrong output values.
// -----------------------------------------------------------------------------
module tb_bias_post_proc;

  localparam int ACC_WIDTH     = 20;
  localparam int BIAS_WIDTH    = 8;
  localparam int OUT_WIDTH     = 8;
  localparam int PIXELS_PER_CH = 16;
  localparam int SHIFT_WIDTH   = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [15:0]            num_ch;
  logic [SHIFT_WIDTH-1:0] shift_amt;
  logic [BIAS_WIDTH-1:0]  bias_src;
  logic [BIAS_WIDTH-1:0]  bias_buf = '0;
  logic                   bias_read;
  logic                   psum_valid;
  logic                   psum_ready;
  logic [ACC_WIDTH-1:0]   psum_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   ch_done;
  logic                   done;
  logic                   busy;

  always #5 clk = ~clk;

  // Bias buffer: tracks its input while bias_read is low, holds otherwise.
  always @(posedge clk) begin
    if (!bias_read) bias_buf <= bias_src;
  end

  bias_post_proc #(
    .ACC_WIDTH    (ACC_WIDTH),
    .BIAS_WIDTH   (BIAS_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH),
    .PIXELS_PER_CH(PIXELS_PER_CH),
    .SHIFT_WIDTH  (SHIFT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_ch    (num_ch),
    .shift_amt (shift_amt),
    .bias_in   (bias_buf),
    .bias_read (bias_read),
    .psum_valid(psum_valid),
    .psum_ready(psum_ready),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ch_done   (ch_done),
    .done      (done),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor, sampled on the falling edge (mid-cycle)
  // ---------------------------------------------------------------------------
  logic stat_clr = 1'b0;
  int cyc, acc_cnt, out_cnt, vld_cnt, chd_cnt, done_cnt, load_cnt, blk_cnt, hold_err;
  int got[64];
  int acc_cyc[64];
  int out_cyc[64];
  logic                 prev_stall;
  logic [OUT_WIDTH-1:0] prev_data;

  always @(negedge clk) begin
    if (stat_clr) begin
      cyc <= 0; acc_cnt <= 0; out_cnt <= 0; vld_cnt <= 0; chd_cnt <= 0;
      done_cnt <= 0; load_cnt <= 0; blk_cnt <= 0; hold_err <= 0;
      prev_stall <= 1'b0; prev_data <= '0;
    end else begin
      cyc <= cyc + 1;
      if (psum_valid && psum_ready) begin
        if (acc_cnt < 64) acc_cyc[acc_cnt] <= cyc;
        acc_cnt <= acc_cnt + 1;
      end
      if (out_valid && out_ready) begin
        if (out_cnt < 64) begin
          got[out_cnt]     <= int'($signed(out_data));
          out_cyc[out_cnt] <= cyc;
        end
        out_cnt <= out_cnt + 1;
      end
      if (out_valid) vld_cnt <= vld_cnt + 1;
      if (ch_done) chd_cnt <= chd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (busy && !bias_read) load_cnt <= load_cnt + 1;
      if (busy && bias_read && psum_valid && !psum_ready) blk_cnt <= blk_cnt + 1;
      if (prev_stall && (!out_valid || out_data != prev_data)) hold_err <= hold_err + 1;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  task automatic clear_stats();
    stat_clr = 1'b1;
    @(negedge clk);
    #1 stat_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus tables and pass driver
  // ---------------------------------------------------------------------------
  int psum_tab[64];
  int bias_tab[4];
  int exp_tab[64];

  // One layer pass. out_ready is low for loop cycles [s_lo, s_hi); an extra
  // start (with a different num_ch) is pulsed at loop cycle xs.
  task automatic run_pass(input int nch, input int shamt, input int total,
                          input int s_lo, input int s_hi, input int xs);
    clear_stats();
    @(posedge clk); #1;
    start      = 1'b1;
    num_ch     = 16'(nch);
    shift_amt  = SHIFT_WIDTH'(shamt);
    bias_src   = BIAS_WIDTH'(bias_tab[0]);
    psum_valid = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      int idx;
      int bch;
      idx        = (acc_cnt < 63) ? acc_cnt : 63;
      bch        = (acc_cnt / PIXELS_PER_CH < 3) ? acc_cnt / PIXELS_PER_CH : 3;
      psum_valid = (acc_cnt < total);
      psum_in    = ACC_WIDTH'(psum_tab[idx]);
      bias_src   = BIAS_WIDTH'(bias_tab[bch]);
      out_ready  = !(c >= s_lo && c < s_hi);
      start      = (c == xs);
      num_ch     = (c == xs) ? 16'd3 : 16'(nch);
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    out_ready  = 1'b1;
    start      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Returns the first output that differs from exp_tab, or exp_tab[0] if all
  // n outputs match and exactly n were produced (else -9999).
  function automatic int first_bad(input int n);
    if (out_cnt != n) return -9999;
    for (int i = 0; i < n; i++) begin
      if (got[i] != exp_tab[i]) return got[i];
    end
    return exp_tab[0];
  endfunction

  typedef struct {
    string name;
    int    shamt;
    int    bias;
    int    psum;
    int    exp_sat;
    int    exp_relu;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Arithmetic vectors: {name, shift, bias, psum, expected, expected w/ ReLU}
    vecs[0]  = '{"plain",          0,    0,       5,    5,   5};
    vecs[1]  = '{"round_up_1p5",   2,    0,       6,    2,   2};
    vecs[2]  = '{"round_neg_1p5",  2,    0,      -6,   -1,   0};
    vecs[3]  = '{"sat_pos",        0,    0,  100000,  127, 127};
    vecs[4]  = '{"sat_neg",        0,    0, -100000, -128,   0};
    vecs[5]  = '{"round_1p5_sh1",  1,    0,       3,    2,   2};
    vecs[6]  = '{"round_m1p5_sh1", 1,    0,      -3,   -1,   0};
    vecs[7]  = '{"bias_then_sh3",  3,    5,     -13,   -1,   0};
    vecs[8]  = '{"bias_sat_neg",   0, -128,      -1, -128,   0};
    vecs[9]  = '{"bias_sat_pos",   0,  127,       1,  127, 127};
    vecs[10] = '{"sat_after_sh4",  4,    0,    2040,  127, 127};
    vecs[11] = '{"min_psum_sh20", 20, -128, -524288,   -1,   0};
    vecs[12] = '{"min_psum_sh21", 21,    0, -524288,    0,   0};
    vecs[13] = '{"huge_shift",    31,    0,   -1000,    0,   0};

    rst_n      = 1'b0;
    start      = 1'b0;
    num_ch     = '0;
    shift_amt  = '0;
    bias_src   = '0;
    psum_valid = 1'b0;
    psum_in    = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // ---- reset state ----
    check("rst bias_read",  int'(bias_read),  0);
    check("rst psum_ready", int'(psum_ready), 0);
    check("rst out_valid",  int'(out_valid),  0);
    check("rst out_data",   int'(out_data),   0);
    check("rst ch_done",    int'(ch_done),    0);
    check("rst done",       int'(done),       0);
    check("rst busy",       int'(busy),       0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven arithmetic: one single-channel pass per vector ----
    foreach (vecs[v]) begin
      int e;
`ifdef POST_RELU_EN
      e = vecs[v].exp_relu;
`else
      e = vecs[v].exp_sat;
`endif
      for (int i = 0; i < PIXELS_PER_CH; i++) begin
        psum_tab[i] = vecs[v].psum;
        exp_tab[i]  = e;
      end
      bias_tab[0] = vecs[v].bias;
      run_pass(1, vecs[v].shamt, PIXELS_PER_CH, -1, -1, -1);
      check(vecs[v].name, first_bad(PIXELS_PER_CH), e);
    end

    // ---- two channels, bias 10 then -3, psum 1..16 each ----
    bias_tab[0] = 10;
    bias_tab[1] = -3;
    for (int i = 0; i < 32; i++) begin
      psum_tab[i] = (i % 16) + 1;
      exp_tab[i]  = (i % 16) + 1 + ((i < 16) ? 10 : -3);
    end
    run_pass(2, 0, 32, -1, -1, -1);
    check("main all outputs", first_bad(32), 11);
    check("main ch0 first",   got[0], 11);
    check("main ch0 last",    got[15], 26);
    check("main ch1 first",   got[16], -2);
    check("main ch1 last",    got[31], 13);
    begin
      int lat_bad = 0;
      for (int i = 0; i < 32; i++) if (out_cyc[i] - acc_cyc[i] != 2) lat_bad++;
      check("main latency errors", lat_bad, 0);
    end
    check("main load cycles", load_cnt, 1);
    check("main ch_done",     chd_cnt, 2);
    check("main done",        done_cnt, 1);
    check("main busy after",  int'(busy), 0);

    // ---- downstream stall: out_ready low 4 cycles while psums keep coming ----
    bias_tab[0] = 0;
    for (int i = 0; i < 16; i++) begin
      psum_tab[i] = i + 1;
      exp_tab[i]  = i + 1;
    end
    run_pass(1, 0, 16, 6, 10, -1);
    check("stall all outputs",  first_bad(16), 1);
    check("stall blocked cyc",  blk_cnt, 4);
    check("stall hold errors",  hold_err, 0);
    check("stall done",         done_cnt, 1);

    // ---- num_ch = 0 runs one channel; a start mid-pass is ignored ----
    bias_tab[0] = 5;
    for (int i = 0; i < 16; i++) begin
      psum_tab[i] = 3 * i - 20;
      exp_tab[i]  = 3 * i - 15;
    end
    run_pass(0, 0, 16, -1, -1, 3);
    check("nch0 all outputs", first_bad(16), -15);
    check("nch0 ch_done",     chd_cnt, 1);
    check("nch0 done",        done_cnt, 1);
    check("nch0 load cycles", load_cnt, 0);

    // ---- reset in the middle of a pass ----
    bias_tab[0] = 0;
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; num_ch = 16'd1; shift_amt = '0; bias_src = '0;
    @(posedge clk); #1;
    start = 1'b0; psum_valid = 1'b1; psum_in = ACC_WIDTH'(7); out_ready = 1'b1;
    for (int c = 0; c < 100 && acc_cnt < 5; c++) begin
      @(posedge clk); #1;
    end
    check("mid-run accepted", acc_cnt, 5);
    #1 rst_n = 1'b0;
    #1;
    check("midrst bias_read",  int'(bias_read),  0);
    check("midrst psum_ready", int'(psum_ready), 0);
    check("midrst out_valid",  int'(out_valid),  0);
    check("midrst out_data",   int'(out_data),   0);
    check("midrst ch_done",    int'(ch_done),    0);
    check("midrst done",       int'(done),       0);
    check("midrst busy",       int'(busy),       0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_stats();
    repeat (40) @(posedge clk);
    #1;
    check("post-rst out_valid cycles", vld_cnt, 0);
    check("post-rst accepts",          acc_cnt, 0);
    check("post-rst busy",             int'(busy), 0);
    psum_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
